// File: rtl/aes_encrypt_ctrl_pkg.sv
// aes_encrypt_ctrl_pkg: shared AES-128 constants, FSM encoding and byte helpers
// Contents: NUM_ROUNDS, RCON_INIT, RCON_POLY, state_t {IDLE, ROUND, DONE},
//           sbox() forward S-box lookup, xtime() GF(2^8) multiply by 2
package aes_encrypt_ctrl_pkg;
   localparam logic [3:0] NUM_ROUNDS = 4'd10;
   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] RCON_POLY  = 8'h1b;
   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;
   // Byte v of the table lives in bits [2047-8v -: 8]
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction
endpackage

// File: rtl/encrypt_round.sv
// encrypt_round: combinational AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// Ports: i_state round input, i_rkey round key, i_last skips MixColumns,
//        o_state round output
module encrypt_round
   import aes_encrypt_ctrl_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_rkey,
   input  logic         i_last,
   output logic [127:0] o_state
);
   // Byte index 4*c+r is row r of column c
   logic [7:0] w_sr [16];
   logic [7:0] w_mc [16];
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_sr[4*c+r] = sbox(i_state[127-8*(4*((c+r)%4)+r) -: 8]);
         assign w_mc[4*c+r] = xtime(w_sr[4*c+r]) ^ xtime(w_sr[4*c+(r+1)%4]) ^ w_sr[4*c+(r+1)%4]
                            ^ w_sr[4*c+(r+2)%4] ^ w_sr[4*c+(r+3)%4];
         assign o_state[127-8*(4*c+r) -: 8] = (i_last ? w_sr[4*c+r] : w_mc[4*c+r]) ^ i_rkey[127-8*(4*c+r) -: 8];
      end
   end
endmodule

// File: rtl/key_expand_step.sv
// key_expand_step: combinational AES-128 next-round-key generator
// Ports: i_key current round key (FIPS-197 byte order), i_rcon round constant,
//        o_key following round key
module key_expand_step
   import aes_encrypt_ctrl_pkg::*;
(
   input  logic [127:0] i_key,
   input  logic [7:0]   i_rcon,
   output logic [127:0] o_key
);
   logic [31:0] w_t, w_w0, w_w1, w_w2, w_w3;
   // SubWord(RotWord(w3)) ^ {rcon, 24'h0}
   assign w_t  = {sbox(i_key[23:16]) ^ i_rcon, sbox(i_key[15:8]), sbox(i_key[7:0]), sbox(i_key[31:24])};
   assign w_w0 = i_key[127:96] ^ w_t;
   assign w_w1 = i_key[95:64] ^ w_w0;
   assign w_w2 = i_key[63:32] ^ w_w1;
   assign w_w3 = i_key[31:0] ^ w_w2;
   assign o_key = {w_w0, w_w1, w_w2, w_w3};
endmodule

// File: rtl/aes_encrypt_ctrl.sv
// aes_encrypt_ctrl: iterative AES-128 encryptor, one round per clock
// Ports: clk, reset_n (async active-low); in_valid/in_ready/in_data/in_key accept a job;
//        abort cancels it; out_valid/out_ready/out_data deliver the ciphertext;
//        busy is high while a job is in flight or waiting to be taken
module aes_encrypt_ctrl
   import aes_encrypt_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   input  logic         abort,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   state_t       r_state, w_next;
   logic [127:0] r_data, r_rkey, w_nk, w_rnd;
   logic [3:0]   r_cnt;
   logic [7:0]   r_rcon;
   logic         w_last, w_accept;
   assign w_last   = r_cnt == NUM_ROUNDS;
   assign w_accept = r_state == IDLE && in_valid && !abort;
   key_expand_step u_key (
      .i_key  (r_rkey),
      .i_rcon (r_rcon),
      .o_key  (w_nk)
   );
   encrypt_round u_round (
      .i_state (r_data),
      .i_rkey  (w_nk),
      .i_last  (w_last),
      .o_state (w_rnd)
   );
   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:    w_next = w_accept ? ROUND : IDLE;
         ROUND:   w_next = abort ? IDLE : (w_last ? DONE : ROUND);
         DONE:    w_next = (abort || out_ready) ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_rkey  <= '0;
         r_cnt   <= '0;
         r_rcon  <= RCON_INIT;
      end else begin
         r_state <= w_next;
         if (abort && r_state != IDLE) begin
            r_data <= '0;
            r_rkey <= '0;
         end else if (w_accept) begin
            r_data <= in_data ^ in_key;
            r_rkey <= in_key;
            r_cnt  <= 4'd1;
            r_rcon <= RCON_INIT;
         end else if (r_state == ROUND) begin
            r_data <= w_rnd;
            r_rkey <= w_nk;
            r_rcon <= xtime(r_rcon);
            // hold at the final round so the counter never passes NUM_ROUNDS
            r_cnt  <= w_last ? r_cnt : r_cnt + 4'd1;
         end
      end
   end
   assign in_ready  = r_state == IDLE;
   assign out_valid = r_state == DONE;
   assign busy      = r_state == ROUND || r_state == DONE;
   assign out_data  = out_valid ? r_data : '0;
endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// tb_aes_encrypt_ctrl: directed FIPS-197 vectors plus randomized traffic against a byte-level AES model
module tb_aes_encrypt_ctrl;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] RK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [127:0] in_key = '0;
   logic         abort = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         busy;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int m_age = 0;
   logic [255:0] m_res = '0;
   logic [7:0] sbox_t [256];
   int acc_q [$];
   logic [127:0] out_q [$];

   aes_encrypt_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Returns {ciphertext, final round key}
   function automatic logic [255:0] aes(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0] s [16];
      logic [7:0] k [16];
      logic [7:0] t [16];
      logic [7:0] rc = 8'h01;
      logic [127:0] ct = '0;
      logic [127:0] rk = '0;
      for (int i = 0; i < 16; i++) begin
         k[i] = key[127-8*i -: 8];
         s[i] = pt[127-8*i -: 8] ^ k[i];
      end
      for (int rnd = 1; rnd <= 10; rnd++) begin
         t[0] = sbox_t[k[13]] ^ rc;
         t[1] = sbox_t[k[14]];
         t[2] = sbox_t[k[15]];
         t[3] = sbox_t[k[12]];
         for (int i = 0; i < 16; i++) k[i] = k[i] ^ ((i < 4) ? t[i] : k[(i+12)%16]);
         rc = gmul(rc, 8'h02);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[4*c+r] = (rnd == 10) ? t[4*c+r] :
                  gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4]) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      end
      for (int i = 0; i < 16; i++) begin
         ct[127-8*i -: 8] = s[i];
         rk[127-8*i -: 8] = k[i];
      end
      return {ct, rk};
   endfunction

   // Model: m_age counts edges since accept; result is presented once 10 rounds have elapsed
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_age <= 0;
      else if (m_age == 0) begin
         if (in_valid && !abort) begin
            m_age <= 1;
            m_res <= aes(in_data, in_key);
         end
      end else if (abort) m_age <= 0;
      else if (m_age < 11) m_age <= m_age + 1;
      else if (out_ready) m_age <= 0;
   end

   always @(posedge clk) begin
      cyc++;
      if (reset_n && in_valid && in_ready && !abort) acc_q.push_back(cyc);
      if (out_valid && out_ready) out_q.push_back(out_data);
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_age == 0);
      chk("out_valid", out_valid, m_age == 11);
      chk("busy", busy, m_age != 0);
      chk("out_data", out_data, (m_age == 11) ? m_res[255:128] : 128'h0);
      if (m_age == 11) chk("rkey_final", dut.r_rkey, m_res[127:0]);
   end

   task automatic start_job(input logic [127:0] pt, input logic [127:0] key);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pt;
      in_key   = key;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_known(input string name, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] ct);
      int n;
      start_job(pt, key);
      wait_out(n);
      chk({name, "_latency"}, n, 10);
      chk({name, "_ct"}, out_data, ct);
   endtask

   initial begin
      int n;
      logic [7:0] inv;
      logic [255:0] r;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, v[7:0]);
         sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      chk("model_sbox_00", sbox_t[0], 8'h63);
      chk("model_sbox_53", sbox_t[8'h53], 8'hed);
      r = aes(PT_B, KEY_B);
      chk("model_ct_b", r[255:128], CT_B);
      chk("model_rk_b", r[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      r = aes(PT_C, KEY_C);
      chk("model_ct_c", r[255:128], CT_C);
      chk("model_rk_c", r[127:0], RK_C);
      r = aes('0, '0);
      chk("model_ct_zero", r[255:128], CT_Z);

      #1 reset_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 128'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_state_reg", dut.r_data, 128'h0);
      chk("rst_rkey", dut.r_rkey, 128'h0);
      chk("rst_cnt", dut.r_cnt, 4'd0);
      chk("rst_rcon", dut.r_rcon, 8'h01);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      out_ready = 1'b1;
      run_known("app_b", PT_B, KEY_B, CT_B);
      @(negedge clk);
      chk("app_b_idle_ready", in_ready, 1'b1);

      out_ready = 1'b0;
      start_job(PT_C, KEY_C);
      wait_out(n);
      chk("app_c_latency", n, 10);
      chk("app_c_rkey10", dut.r_rkey, RK_C);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("bp_out_data", out_data, CT_C);
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid, 1'b0);
      chk("bp_release_ready", in_ready, 1'b1);

      in_valid = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      chk("idle_abort_busy", busy, 1'b0);
      chk("idle_abort_ready", in_ready, 1'b1);
      in_valid = 1'b0;
      abort    = 1'b0;

      acc_q.delete();
      out_q.delete();
      in_data  = '0;
      in_key   = '0;
      in_valid = 1'b1;
      n = 0;
      while (acc_q.size() < 2 && n < 40) begin
         @(negedge clk);
         n++;
         if (acc_q.size() == 1) begin
            in_data = PT_B;
            in_key  = KEY_B;
         end
      end
      in_valid = 1'b0;
      n = 0;
      while (out_q.size() < 2 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_count", out_q.size(), 2);
      if (out_q.size() >= 2) begin
         chk("b2b_first", out_q[0], CT_Z);
         chk("b2b_second", out_q[1], CT_B);
      end
      if (acc_q.size() >= 2) chk("b2b_gap", acc_q[1] - acc_q[0], 12);

      start_job(PT_C, KEY_C);
      repeat (4) @(negedge clk);
      chk("abort_at_cnt", dut.r_cnt, 4'd5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ready", in_ready, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_valid", out_valid, 1'b0);
      chk("abort_state_reg", dut.r_data, 128'h0);
      chk("abort_rkey", dut.r_rkey, 128'h0);
      run_known("after_abort", PT_C, KEY_C, CT_C);

      start_job(PT_B, KEY_B);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_ready", in_ready, 1'b1);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_data", out_data, 128'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      chk("lost_job_no_valid", n, 0);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         in_key    = {$urandom, $urandom, $urandom, $urandom};
         out_ready = $urandom_range(0, 3) != 0;
         abort     = $urandom_range(0, 40) == 0;
      end
      in_valid  = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b1;
      repeat (20) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
